// File: rtl/mems_sample_reader.sv
// Avalon-MM read master that sweeps the MEMS sample window in RAM and streams the bytes out through a small show-ahead FIFO.
// Define MEMS_SAMPLE_READER_LOOP_EN for circular reading with a stop input; the default build does a single pass.
module mems_sample_reader #(
  parameter logic [31:0] BASE_ADDR   = 32'd0,
  parameter int          NUM_SAMPLES = 300,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
`ifdef MEMS_SAMPLE_READER_LOOP_EN
  input  logic        stop,
`endif
  output logic [31:0] address,
  output logic        read,
  input  logic [7:0]  readdata,
  input  logic        waitrequest,
  output logic [7:0]  sample_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        busy,
  output logic        done
);

  localparam int IDX_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, WAIT_SPACE, DRAIN} state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  index_reg, index_next;
  logic [31:0]       address_reg, address_next;
  logic              read_reg, read_next;
  logic              busy_reg, busy_next;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]    count_reg, count_next;
  logic              push, pop;
  logic              stop_req;
  logic              loop_en;

`ifdef MEMS_SAMPLE_READER_LOOP_EN
  logic stop_pending_reg, stop_pending_next;

  // A stop seen at any point during the pass is remembered until the next accepted read.
  assign stop_pending_next = (state_reg != IDLE) && (stop_pending_reg || stop);
  assign stop_req          = stop || stop_pending_reg;
  assign loop_en           = 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stop_pending_reg <= 1'b0;
    else       stop_pending_reg <= stop_pending_next;
  end
`else
  assign stop_req = 1'b0;
  assign loop_en  = 1'b0;
`endif

  assign push         = read_reg && !waitrequest;
  assign sample_valid = (count_reg != '0);
  assign pop          = sample_valid && sample_ready;
  assign sample_data  = sample_valid ? fifo_mem[rd_ptr_reg] : 8'd0;

  assign address = address_reg;
  assign read    = read_reg;
  assign busy    = busy_reg;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  // Storage is not reset; sample_data is masked while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_reg] <= readdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      index_reg   <= '0;
      address_reg <= 32'd0;
      read_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      index_reg   <= index_next;
      address_reg <= address_next;
      read_reg    <= read_next;
      busy_reg    <= busy_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    index_next   = index_reg;
    address_next = address_reg;
    read_next    = read_reg;
    busy_next    = busy_reg;
    done         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          index_next   = '0;
          address_next = BASE_ADDR;
          read_next    = 1'b1;
          busy_next    = 1'b1;
          state_next   = READ;
        end
      end
      READ: begin
        if (!waitrequest) begin
          if (stop_req || (!loop_en && index_reg == LAST_IDX)) begin
            read_next  = 1'b0;
            state_next = DRAIN;
          end else begin
            if (index_reg == LAST_IDX) begin
              index_next   = '0;
              address_next = BASE_ADDR;
            end else begin
              index_next   = index_reg + IDX_ONE;
              address_next = address_reg + 32'd1;
            end
            // Stop issuing before the FIFO could overflow; resume from WAIT_SPACE.
            if (count_next == FULL_CNT) begin
              read_next  = 1'b0;
              state_next = WAIT_SPACE;
            end
          end
        end
      end
      WAIT_SPACE: begin
        if (count_reg != FULL_CNT) begin
          read_next  = 1'b1;
          state_next = READ;
        end
      end
      DRAIN: begin
        if (count_reg == '0) begin
          done       = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mems_sample_reader.sv
// Directed bench for mems_sample_reader: RAM model returning addr[7:0], table of pass scenarios plus reset-mid-pass sequence.
module tb_mems_sample_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] address;
  logic        read;
  logic [7:0]  readdata;
  logic        waitrequest;
  logic [7:0]  sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        busy;
  logic        done;
`ifdef MEMS_SAMPLE_READER_LOOP_EN
  logic        stop = 1'b0;
`endif

  mems_sample_reader dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
`ifdef MEMS_SAMPLE_READER_LOOP_EN
    .stop         (stop),
`endif
    .address      (address),
    .read         (read),
    .readdata     (readdata),
    .waitrequest  (waitrequest),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit stall;       // 3 waitrequest cycles on every read
    int ready_delay; // cycles with sample_ready=0 after start
    int extra_start; // cycle at which a stray start is pulsed (0 = none)
    int exp_bytes;
    int exp_done;
    int exp_cyc;     // cycle of the done pulse (0 = not timed)
  } tv_t;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  rx[$];
  logic [31:0] acc[$];
  int          cyc, done_cnt, done_cyc, stall_bad, stall_cnt;
  bit          stall_en, prev_stall;
  logic [31:0] prev_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge with start/sample_ready already set; models the RAM and
  // records transfers for the coming posedge, then advances to the next negedge.
  task automatic cycle();
    if (prev_stall && (!read || address !== prev_addr)) stall_bad++;
    if (read) begin
      if (stall_en && stall_cnt < 3) begin
        waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        waitrequest = 1'b0;
        stall_cnt = 0;
        acc.push_back(address);
      end
    end else begin
      waitrequest = 1'b0;
      stall_cnt = 0;
    end
    readdata = address[7:0];
    prev_stall = read && waitrequest;
    prev_addr = address;
    if (sample_valid && sample_ready) rx.push_back(sample_data);
    @(negedge clock);
    cyc++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic check_stream(input int k, input int exp_bytes);
    int bad_data = 0;
    int bad_addr = 0;
    check($sformatf("pass%0d byte count", k), rx.size(), exp_bytes);
    check($sformatf("pass%0d read count", k), acc.size(), exp_bytes);
    for (int i = 0; i < rx.size(); i++)
      if (rx[i] !== 8'(i)) bad_data++;
    for (int i = 0; i < acc.size(); i++)
      if (acc[i] !== 32'(i)) bad_addr++;
    check($sformatf("pass%0d data errors", k), bad_data, 0);
    check($sformatf("pass%0d address errors", k), bad_addr, 0);
  endtask

  task automatic run_pass(input int k, input tv_t v);
    rx.delete();
    acc.delete();
    cyc = 0; done_cnt = 0; done_cyc = 0; stall_bad = 0; stall_cnt = 0;
    prev_stall = 1'b0;
    stall_en = v.stall;
    start = 1'b1;
    sample_ready = (v.ready_delay == 0);
    cycle();
    start = 1'b0;
    check($sformatf("pass%0d busy after start", k), busy, 1);
    while (done_cnt == 0 && cyc < 5000) begin
      sample_ready = (cyc >= v.ready_delay);
      start = (v.extra_start != 0 && cyc == v.extra_start);
      cycle();
      start = 1'b0;
      if (cyc == v.ready_delay) begin
        check($sformatf("pass%0d reads before space", k), acc.size(), 4);
        check($sformatf("pass%0d read low while full", k), read, 0);
        check($sformatf("pass%0d valid while full", k), sample_valid, 1);
      end
    end
    check($sformatf("pass%0d done seen", k), done_cnt, v.exp_done);
    if (v.exp_cyc != 0) check($sformatf("pass%0d done cycle", k), done_cyc, v.exp_cyc);
    sample_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    check($sformatf("pass%0d busy after done", k), busy, 0);
    check($sformatf("pass%0d single done", k), done_cnt, v.exp_done);
    check($sformatf("pass%0d stall stability", k), stall_bad, 0);
    check_stream(k, v.exp_bytes);
    if (acc.size() > 4) check($sformatf("pass%0d 5th read addr", k), acc[4], 32'd4);
    $display("pass %0d: stall=%0d ready_delay=%0d bytes=%0d done_cycle=%0d", k, v.stall, v.ready_delay, rx.size(), done_cyc);
  endtask

  tv_t tv [5];

  initial begin
    tv[0] = '{stall: 1'b0, ready_delay: 0,  extra_start: 0,   exp_bytes: 300, exp_done: 1, exp_cyc: 302};
    tv[1] = '{stall: 1'b1, ready_delay: 0,  extra_start: 0,   exp_bytes: 300, exp_done: 1, exp_cyc: 0};
    tv[2] = '{stall: 1'b0, ready_delay: 20, extra_start: 0,   exp_bytes: 300, exp_done: 1, exp_cyc: 0};
    tv[3] = '{stall: 1'b0, ready_delay: 0,  extra_start: 100, exp_bytes: 300, exp_done: 1, exp_cyc: 302};
    tv[4] = '{stall: 1'b0, ready_delay: 0,  extra_start: 301, exp_bytes: 300, exp_done: 1, exp_cyc: 302};

    reset = 1'b1; start = 1'b0; waitrequest = 1'b0; readdata = 8'd0; sample_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("reset address", address, 0);
    check("reset read", read, 0);
    check("reset sample_data", sample_data, 0);
    check("reset sample_valid", sample_valid, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    reset = 1'b0;
    @(negedge clock);

    for (int k = 0; k < 5; k++) run_pass(k, tv[k]);

    // Reset in the middle of a pass, then a fresh pass must restart at BASE_ADDR.
    rx.delete(); acc.delete();
    cyc = 0; stall_en = 1'b0; stall_cnt = 0; prev_stall = 1'b0;
    sample_ready = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    while (acc.size() < 151 && cyc < 1000) cycle();
    check("midpass reached index 150", acc.size(), 151);
    #2 reset = 1'b1;
    #1;
    check("async reset address", address, 0);
    check("async reset read", read, 0);
    check("async reset sample_data", sample_data, 0);
    check("async reset sample_valid", sample_valid, 0);
    check("async reset busy", busy, 0);
    check("async reset done", done, 0);
    $display("reset mid-pass: after %0d reads, outputs cleared", acc.size());
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run_pass(5, tv[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
